// File: rtl/fifo64_stream_tx.sv
// Splits a 64-bit word stream into paired 32-bit up/down Avalon-ST beats for one
// acquisition of n_samples words, then raises finalizacion until enable drops.
module fifo64_stream_tx #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             reset_op,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             s_valid,
    input  logic [63:0]      s_data,
    output logic             s_ready,
    output logic             up_valid,
    output logic [31:0]      up_data,
    input  logic             up_ready,
    output logic             down_valid,
    output logic [31:0]      down_data,
    input  logic             down_ready,
    output logic             finalizacion,
    output logic [CNT_W-1:0] sent_count,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_ABORT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             enable_q;
    logic [CNT_W-1:0] n_lat_q, n_lat_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
    logic [63:0]      hold_q, hold_d;
    logic             pend_up_q, pend_up_d;
    logic             pend_dn_q, pend_dn_d;

    logic enable_rise;
    logic fire_up, fire_dn;
    logic rem_up, rem_dn;
    logic free, load, word_done;

    // Every port pair is valid/ready: a transfer happens on a clock edge where both
    // are high; valid never depends on ready, and data is held while valid waits.
    assign enable_rise = enable & ~enable_q;
    assign fire_up     = pend_up_q & up_ready;
    assign fire_dn     = pend_dn_q & down_ready;
    assign rem_up      = pend_up_q & ~fire_up;
    assign rem_dn      = pend_dn_q & ~fire_dn;
    assign free        = ~rem_up & ~rem_dn;
    assign s_ready     = (state_q == ST_RUN) & free & (acc_cnt_q < n_lat_q);
    assign load        = s_valid & s_ready;
    // A word counts as sent in the cycle its last outstanding half leaves.
    assign word_done   = (fire_up | fire_dn) & ~rem_up & ~rem_dn;

    assign up_valid     = pend_up_q;
    assign down_valid   = pend_dn_q;
    assign up_data      = hold_q[63:32];
    assign down_data    = hold_q[31:0];
    assign finalizacion = (state_q == ST_DONE);
    assign sent_count   = sent_cnt_q;
    assign dbg_state    = state_q;

    always_comb begin
        state_d    = state_q;
        n_lat_d    = n_lat_q;
        acc_cnt_d  = acc_cnt_q;
        sent_cnt_d = sent_cnt_q;
        hold_d     = hold_q;
        pend_up_d  = load | rem_up;
        pend_dn_d  = load | rem_dn;

        if (load) begin
            hold_d    = s_data;
            acc_cnt_d = acc_cnt_q + CNT_ONE;
        end
        if (word_done) begin
            sent_cnt_d = sent_cnt_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable_rise) begin
                    n_lat_d    = n_samples;
                    acc_cnt_d  = '0;
                    sent_cnt_d = '0;
                    state_d    = (n_samples != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_ABORT;
                end else if (acc_cnt_d == n_lat_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!enable) begin
                    state_d = ST_ABORT;
                end else if (!pend_up_d && !pend_dn_d && sent_cnt_d == n_lat_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_ABORT: begin
                if (!pend_up_d && !pend_dn_d) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Operational clear wins over everything; any held word is dropped.
        if (reset_op) begin
            state_d    = ST_IDLE;
            n_lat_d    = '0;
            acc_cnt_d  = '0;
            sent_cnt_d = '0;
            hold_d     = '0;
            pend_up_d  = 1'b0;
            pend_dn_d  = 1'b0;
        end
    end

    // enable_q keeps tracking enable through reset_op so a held-high enable cannot re-arm.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            enable_q   <= 1'b0;
            n_lat_q    <= '0;
            acc_cnt_q  <= '0;
            sent_cnt_q <= '0;
            hold_q     <= '0;
            pend_up_q  <= 1'b0;
            pend_dn_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable;
            n_lat_q    <= n_lat_d;
            acc_cnt_q  <= acc_cnt_d;
            sent_cnt_q <= sent_cnt_d;
            hold_q     <= hold_d;
            pend_up_q  <= pend_up_d;
            pend_dn_q  <= pend_dn_d;
        end
    end

endmodule

// File: tb/tb_fifo64_stream_tx.sv
// Directed bench for fifo64_stream_tx: a driver pushes expected halves on acceptance,
// a negedge monitor pops and compares every up/down beat.
module tb_fifo64_stream_tx;

  localparam int CNT_W = 32;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_ABORT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic             clk;
  logic             reset_n;
  logic             enable;
  logic             reset_op;
  logic [CNT_W-1:0] n_samples;
  logic             s_valid;
  logic [63:0]      s_data;
  logic             s_ready;
  logic             up_valid;
  logic [31:0]      up_data;
  logic             up_ready;
  logic             down_valid;
  logic [31:0]      down_data;
  logic             down_ready;
  logic             finalizacion;
  logic [CNT_W-1:0] sent_count;
  logic [2:0]       dbg_state;

  logic [31:0] exp_up_q[$];
  logic [31:0] exp_dn_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  fifo64_stream_tx #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .reset_op     (reset_op),
    .n_samples    (n_samples),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .up_valid     (up_valid),
    .up_data      (up_data),
    .up_ready     (up_ready),
    .down_valid   (down_valid),
    .down_data    (down_data),
    .down_ready   (down_ready),
    .finalizacion (finalizacion),
    .sent_count   (sent_count),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (dbg_state !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, dbg_state, st);
  endtask

  // driver: offer one word, push its halves when the DUT accepts it
  task automatic send_word(input logic [63:0] w, output int stalls);
    s_valid = 1'b1;
    s_data  = w;
    stalls  = 0;
    @(negedge clk);
    while (!s_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!s_ready) begin
      check("accept_timeout", s_ready, 1);
    end else begin
      exp_up_q.push_back(w[63:32]);
      exp_dn_q.push_back(w[31:0]);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // scoreboard monitor
  logic        up_hold = 1'b0;
  logic        dn_hold = 1'b0;
  logic [31:0] up_prev = '0;
  logic [31:0] dn_prev = '0;

  always @(negedge clk) begin
    if (up_hold && up_valid) check("up_stable", up_data, up_prev);
    if (dn_hold && down_valid) check("down_stable", down_data, dn_prev);
    if (up_valid && up_ready) begin
      if (exp_up_q.size() == 0) check("up_unexpected", up_valid, 0);
      else check("up_data", up_data, exp_up_q.pop_front());
    end
    if (down_valid && down_ready) begin
      if (exp_dn_q.size() == 0) check("down_unexpected", down_valid, 0);
      else check("down_data", down_data, exp_dn_q.pop_front());
    end
    up_hold = up_valid && !up_ready;
    dn_hold = down_valid && !down_ready;
    up_prev = up_data;
    dn_prev = down_data;
  end

  initial begin
    int st;
    int total;
    reset_n    = 1'b0;
    enable     = 1'b0;
    reset_op   = 1'b0;
    n_samples  = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    up_ready   = 1'b1;
    down_ready = 1'b1;

    @(negedge clk);
    check("rst_state", dbg_state, S_IDLE);
    check("rst_s_ready", s_ready, 0);
    check("rst_up_valid", up_valid, 0);
    check("rst_down_valid", down_valid, 0);
    check("rst_fin", finalizacion, 0);
    check("rst_sent", sent_count, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // 1: four words, both readies high
    n_samples = 4;
    enable    = 1'b1;
    total     = 0;
    for (int i = 0; i < 4; i++) begin
      send_word(64'h1111_2222_3333_4444 + 64'(i), st);
      total += st;
    end
    check("t1_stalls", total, 1);
    @(negedge clk);
    check("t1_fin_pre", finalizacion, 0);
    check("t1_drain", dbg_state, S_DRAIN);
    check("t1_last_up_valid", up_valid, 1);
    @(negedge clk);
    check("t1_fin", finalizacion, 1);
    check("t1_done", dbg_state, S_DONE);
    check("t1_sent", sent_count, 4);
    check("t1_s_ready_done", s_ready, 0);
    repeat (3) @(negedge clk);
    check("t1_no_rearm", dbg_state, S_DONE);
    tick();
    enable = 1'b0;
    wait_state(S_IDLE, 2, "t1_idle");
    check("t1_up_q_empty", exp_up_q.size(), 0);
    check("t1_dn_q_empty", exp_dn_q.size(), 0);

    // 2: up_ready low for 3 clks while down_ready stays high
    tick();
    enable = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) send_word(64'h1111_2222_3333_4444 + 64'(i), st);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        up_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t2_down_valid_drop", down_valid, 0);
        check("t2_s_ready_stall", s_ready, 0);
        check("t2_up_valid_held", up_valid, 1);
        check("t2_up_data_held", up_data, 32'h1111_2222);
        @(posedge clk);
        @(posedge clk);
        #1;
        up_ready = 1'b1;
      end
    join
    wait_state(S_DONE, 20, "t2_done");
    check("t2_sent", sent_count, 4);
    check("t2_up_q_empty", exp_up_q.size(), 0);
    check("t2_dn_q_empty", exp_dn_q.size(), 0);
    tick();
    enable = 1'b0;
    wait_state(S_IDLE, 2, "t2_idle");

    // 3: zero-length acquisition, words offered but never accepted
    tick();
    n_samples = 0;
    enable    = 1'b1;
    s_valid   = 1'b1;
    s_data    = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    check("t3_pre_arm", dbg_state, S_IDLE);
    @(negedge clk);
    check("t3_done", dbg_state, S_DONE);
    check("t3_fin", finalizacion, 1);
    check("t3_s_ready", s_ready, 0);
    check("t3_up_valid", up_valid, 0);
    check("t3_down_valid", down_valid, 0);
    check("t3_sent", sent_count, 0);
    tick();
    s_valid = 1'b0;
    enable  = 1'b0;
    wait_state(S_IDLE, 2, "t3_idle");

    // 4: abort after 3 accepts with the last word still held
    tick();
    n_samples = 8;
    enable    = 1'b1;
    for (int i = 0; i < 3; i++) send_word(64'hA5A5_0000_5A5A_0000 + {32'(i), 32'(i)}, st);
    enable   = 1'b0;
    up_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t4_abort", dbg_state, S_ABORT);
    check("t4_s_ready", s_ready, 0);
    check("t4_up_valid", up_valid, 1);
    check("t4_fin_abort", finalizacion, 0);
    tick();
    tick();
    up_ready = 1'b1;
    wait_state(S_IDLE, 5, "t4_idle");
    check("t4_sent", sent_count, 3);
    check("t4_fin", finalizacion, 0);
    check("t4_up_q_empty", exp_up_q.size(), 0);

    // 5: reset_op while the up half is pending
    tick();
    n_samples = 8;
    enable    = 1'b1;
    up_ready  = 1'b0;
    send_word(64'h0BAD_F00D_1234_5678, st);
    @(negedge clk);
    check("t5_pend_up", up_valid, 1);
    tick();
    reset_op = 1'b1;
    tick();
    reset_op = 1'b0;
    @(negedge clk);
    check("t5_up_valid", up_valid, 0);
    check("t5_down_valid", down_valid, 0);
    check("t5_s_ready", s_ready, 0);
    check("t5_sent", sent_count, 0);
    check("t5_state", dbg_state, S_IDLE);
    check("t5_up_data", up_data, 0);
    exp_up_q.delete();
    exp_dn_q.delete();
    up_ready = 1'b1;
    @(negedge clk);
    check("t5_no_rearm", dbg_state, S_IDLE);
    tick();
    enable = 1'b0;

    // 6: async reset mid-DRAIN, then a clean 2-word run
    tick();
    n_samples = 1;
    enable    = 1'b1;
    up_ready  = 1'b0;
    send_word(64'h7777_8888_9999_AAAA, st);
    @(negedge clk);
    check("t6_drain", dbg_state, S_DRAIN);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_up_valid", up_valid, 0);
    check("t6_async_down_valid", down_valid, 0);
    check("t6_async_s_ready", s_ready, 0);
    check("t6_async_fin", finalizacion, 0);
    check("t6_async_sent", sent_count, 0);
    check("t6_async_data", {up_data, down_data}, 0);
    check("t6_async_state", dbg_state, S_IDLE);
    exp_up_q.delete();
    exp_dn_q.delete();
    enable   = 1'b0;
    up_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    n_samples = 2;
    enable    = 1'b1;
    send_word(64'h0102_0304_0506_0708, st);
    send_word(64'h1112_1314_1516_1718, st);
    wait_state(S_DONE, 10, "t6_done");
    check("t6_sent", sent_count, 2);
    check("t6_fin", finalizacion, 1);
    check("t6_up_q_empty", exp_up_q.size(), 0);
    check("t6_dn_q_empty", exp_dn_q.size(), 0);
    tick();
    enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
